// File: rtl/dcache_flush_engine_if.sv
// Bus bundle between the flush engine, the dcache SRAM port and the
// Data_Memory enable/write/ack port.
interface dcache_flush_engine_if #(
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned WAY_W  = 1,
    parameter int unsigned TAG_W  = 25,
    parameter int unsigned LINE_W = 256,
    parameter int unsigned ADDR_W = 32
);
    logic [IDX_W-1:0]  sram_idx_o;
    logic [WAY_W-1:0]  sram_way_o;
    logic [TAG_W-1:0]  sram_tag_i;
    logic [LINE_W-1:0] sram_data_i;
    logic              sram_wr_o;
    logic [TAG_W-1:0]  sram_tag_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic              mem_ack_i;

    modport master (
        output sram_idx_o, sram_way_o, sram_wr_o, sram_tag_o,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        input  sram_tag_i, sram_data_i, mem_ack_i
    );

    modport slave (
        input  sram_idx_o, sram_way_o, sram_wr_o, sram_tag_o,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        output sram_tag_i, sram_data_i, mem_ack_i
    );
endinterface

// File: rtl/dcache_flush_engine.sv
// Data cache flush sequencer: visits every {set, way}, writes valid+dirty
// lines back to memory, then clears dirty (and optionally valid) in the tag.
module dcache_flush_engine #(
    parameter int unsigned NUM_SETS = 16,
    parameter int unsigned NUM_WAYS = 2,
    parameter int unsigned TAG_W    = 25,
    parameter int unsigned LINE_W   = 256,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned OFFSET_W = 5,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_req_i,
    input  logic                 invalidate_i,
    output logic                 flush_busy_o,
    output logic                 flush_done_o,
    output logic [CNT_W-1:0]     wb_count_o,
    output logic [CNT_W-1:0]     flush_cycles_o,
    dcache_flush_engine_if.master bus
);
    localparam int unsigned IDX_W  = $clog2(NUM_SETS);
    localparam int unsigned WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int unsigned ATAG_W = TAG_W - 2;
    localparam int unsigned RAW_W  = ATAG_W + IDX_W + OFFSET_W;

    typedef enum logic [2:0] {IDLE, SCAN, WB, UPD, DONE} state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [WAY_W-1:0]    way;
    logic                inv_q;
    logic                busy_q;
    logic                done_q;
    logic                sram_wr_q;
    logic [TAG_W-1:0]    sram_tag_q;
    logic                mem_en_q;
    logic                mem_wr_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [LINE_W-1:0]   mem_data_q;
    logic [CNT_W-1:0]    wb_cnt_q;
    logic [CNT_W-1:0]    cyc_cnt_q;

    logic                tag_valid;
    logic                tag_dirty;
    logic [ATAG_W-1:0]   tag_field;
    logic [RAW_W-1:0]    line_addr;
    logic                last_way;
    logic                at_end;
    logic [IDX_W-1:0]    next_idx;
    logic [WAY_W-1:0]    next_way;

    assign bus.sram_idx_o   = idx;
    assign bus.sram_way_o   = way;
    assign bus.sram_wr_o    = sram_wr_q;
    assign bus.sram_tag_o   = sram_tag_q;
    assign bus.mem_enable_o = mem_en_q;
    assign bus.mem_write_o  = mem_wr_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_data_o   = mem_data_q;
    assign flush_busy_o     = busy_q;
    assign flush_done_o     = done_q;
    assign wb_count_o       = wb_cnt_q;
    assign flush_cycles_o   = cyc_cnt_q;

    // Decode the visited tag word and compute the next walk position.
    always_comb begin
        tag_valid = bus.sram_tag_i[TAG_W-1];
        tag_dirty = bus.sram_tag_i[TAG_W-2];
        tag_field = bus.sram_tag_i[ATAG_W-1:0];
        line_addr = {tag_field, idx, {OFFSET_W{1'b0}}};
        last_way  = (way == WAY_W'(NUM_WAYS - 1));
        at_end    = last_way && (idx == IDX_W'(NUM_SETS - 1));
        next_way  = last_way ? '0 : way + WAY_W'(1);
        next_idx  = last_way ? idx + IDX_W'(1) : idx;
    end

    // Flush sequencer with registered outputs and per-flush statistics.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            idx        <= '0;
            way        <= '0;
            inv_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sram_wr_q  <= 1'b0;
            sram_tag_q <= '0;
            mem_en_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            wb_cnt_q   <= '0;
            cyc_cnt_q  <= '0;
        end else begin
            if (busy_q && (cyc_cnt_q != '1)) begin
                cyc_cnt_q <= cyc_cnt_q + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (flush_req_i) begin
                        inv_q     <= invalidate_i;
                        wb_cnt_q  <= '0;
                        cyc_cnt_q <= '0;
                        idx       <= '0;
                        way       <= '0;
                        busy_q    <= 1'b1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (tag_valid && tag_dirty) begin
                        mem_en_q   <= 1'b1;
                        mem_wr_q   <= 1'b1;
                        mem_addr_q <= ADDR_W'(line_addr);
                        mem_data_q <= bus.sram_data_i;
                        state      <= WB;
                    end else if (tag_valid && inv_q) begin
                        sram_wr_q  <= 1'b1;
                        sram_tag_q <= {2'b00, tag_field};
                        state      <= UPD;
                    end else begin
                        idx <= next_idx;
                        way <= next_way;
                        if (at_end) begin
                            done_q <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                WB: begin
                    if (bus.mem_ack_i) begin
                        mem_en_q   <= 1'b0;
                        mem_wr_q   <= 1'b0;
                        if (wb_cnt_q != '1) begin
                            wb_cnt_q <= wb_cnt_q + CNT_W'(1);
                        end
                        sram_wr_q  <= 1'b1;
                        sram_tag_q <= {tag_valid & ~inv_q, 1'b0, tag_field};
                        state      <= UPD;
                    end
                end
                UPD: begin
                    sram_wr_q <= 1'b0;
                    idx       <= next_idx;
                    way       <= next_way;
                    if (at_end) begin
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        state  <= SCAN;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
